reg_file_mp: RTL

Parametrised multi-port register file for the next-generation MIPS datapath, sized for dual writeback (ALU and load/multi-cycle unit).
- NUM_RD asynchronous read ports and two synchronous write ports with fixed priority.
- Optional write-to-read bypass.
- Per-register pending scoreboard: set at issue, cleared at writeback. Control uses it to stall on load-use and multi-cycle hazards.

---
 rtl/mips_pkg.sv | 17 +
 rtl/reg_scoreboard.sv | 47 ++++
 rtl/reg_file_mp.sv | 105 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath register file: default sizes,
// address-width derivation and writeback port indices.
package mips_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

  // Writeback ports, in ascending priority: the load/multi-cycle port wins.
  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;
  localparam int NUM_WB  = 2;

  function automatic int addr_width(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: set when a long-latency producer issues,
// cleared when its writeback lands. Issue beats a same-cycle writeback.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = addr_width(NUM_REGS),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                issue_en_i,
  input  logic [ADDR_W-1:0]   issue_addr_i,
  input  logic [NUM_WB-1:0]   wr_en_i,
  input  logic [ADDR_W-1:0]   wr0_addr_i,
  input  logic [ADDR_W-1:0]   wr1_addr_i,
  output logic [NUM_REGS-1:0] pending_o,
  output logic                any_pending_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      logic set_r;
      logic clr_r;
      set_r = issue_en_i && (issue_addr_i == ADDR_W'(r)) && !(ZERO_REG && (r == 0));
      clr_r = (wr_en_i[WB_ALU]  && (wr0_addr_i == ADDR_W'(r))) ||
              (wr_en_i[WB_LOAD] && (wr1_addr_i == ADDR_W'(r)));
      pending_d[r] = set_r || (pending_q[r] && !clr_r);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o     = pending_q;
  assign any_pending_o = |pending_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritised
// writeback ports, optional write-to-read bypass and a pending scoreboard.
module reg_file_mp
  import mips_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = addr_width(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_pending_o,
  input  logic                     wr0_en_i,
  input  logic [ADDR_W-1:0]        wr0_addr_i,
  input  logic [DATA_W-1:0]        wr0_data_i,
  input  logic                     wr1_en_i,
  input  logic [ADDR_W-1:0]        wr1_addr_i,
  input  logic [DATA_W-1:0]        wr1_data_i,
  input  logic                     issue_en_i,
  input  logic [ADDR_W-1:0]        issue_addr_i,
  output logic                     any_pending_o
);

  logic [DATA_W-1:0]   reg_q [NUM_REGS];
  logic [DATA_W-1:0]   reg_d [NUM_REGS];
  logic [NUM_WB-1:0]   wr_ok;
  logic [ADDR_W-1:0]   wr_addr [NUM_WB];
  logic [DATA_W-1:0]   wr_data [NUM_WB];
  logic [NUM_REGS-1:0] pending;
  logic                any_pending;

  assign wr_addr[WB_ALU]  = wr0_addr_i;
  assign wr_addr[WB_LOAD] = wr1_addr_i;
  assign wr_data[WB_ALU]  = wr0_data_i;
  assign wr_data[WB_LOAD] = wr1_data_i;
  // Writes to a hardwired r0 are dropped here, so neither storage, bypass
  // nor the scoreboard ever sees them.
  assign wr_ok[WB_ALU]  = wr0_en_i && !(ZERO_REG && (wr0_addr_i == '0));
  assign wr_ok[WB_LOAD] = wr1_en_i && !(ZERO_REG && (wr1_addr_i == '0));

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      reg_d[r] = reg_q[r];
      for (int p = 0; p < NUM_WB; p++) begin
        if (wr_ok[p] && (wr_addr[p] == ADDR_W'(r))) reg_d[r] = wr_data[p];
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int r = 0; r < NUM_REGS; r++) reg_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) reg_q[r] <= reg_d[r];
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .issue_en_i    (issue_en_i),
    .issue_addr_i  (issue_addr_i),
    .wr_en_i       (wr_ok),
    .wr0_addr_i    (wr0_addr_i),
    .wr1_addr_i    (wr1_addr_i),
    .pending_o     (pending),
    .any_pending_o (any_pending)
  );

  assign any_pending_o = any_pending && !reset_i;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              hit;

    assign addr = rd_addr_i[gi*ADDR_W +: ADDR_W];

    // Ascending port order lets the load port override the ALU port.
    always_comb begin
      data = reg_q[addr];
      hit  = 1'b0;
      for (int p = 0; p < NUM_WB; p++) begin
        if (wr_ok[p] && (wr_addr[p] == addr)) begin
          hit = 1'b1;
          if (BYPASS) data = wr_data[p];
        end
      end
      if (reset_i) data = '0;
    end

    assign rd_data_o[gi*DATA_W +: DATA_W] = data;
    assign rd_pending_o[gi] = !reset_i && pending[addr] && !(BYPASS && hit);
  end

endmodule
